pe_vec: RTL and testbench
=========================

// Module: pe_vec
// PURPOSE
//  Multi-lane successor of the scalar PE: LANES independent signed MAC lanes share one serial config
//  port and one control FSM. Runs nPeriod periods; each period is an nLMAC-beat accumulate phase,
//  then an nSHFT-cycle shift/drain phase that emits acc+ipsum per lane. Sits in the systolic PE array.
// PARAMETERS
//  WIDTH        16      operand width (weight, feature), signed
//  LANES        4       parallel MAC lanes
//  MAX_nPERIOD  8       period field width PW=$clog2(MAX_nPERIOD)
//  MAX_nLMAC    12288   MAC-count field width LW=$clog2(MAX_nLMAC)
//  MAX_nSHFT    192     shift-count field width SW=$clog2(MAX_nSHFT)
//  ACC_GUARD    1       guard bits; A_WIDTH=2*WIDTH+ACC_GUARD; CONF_LEN=PW+LW+SW
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rst        in   1               synchronous active-low reset
//  start      in   1               begin run (honoured in IDLE only)
//  iconfig    in   1               serial config bit
//  config_en  in   1               shift iconfig into config reg (IDLE only)
//  in_en      in   1               operand beat valid
//  weight     in   LANES*WIDTH     lane i at [i*WIDTH +: WIDTH]
//  feature    in   LANES*WIDTH     lane i likewise
//  ipsum      in   LANES*A_WIDTH   incoming partial sums
//  opsum      out  LANES*A_WIDTH   outgoing partial sums (registered)
//  out_en     out  1               opsum valid, 1-cycle pulse
//  busy       out  1               FSM not IDLE
//  cfg_err    out  1               sticky: start with a zero field
// BEHAVIOUR
//  Reset (rst=0 at posedge): FSM=IDLE, config reg=0, all counters/acc=0, opsum=0, out_en=0, busy=0,
//   cfg_err=0. Reset mid-run aborts immediately; no out_en pulse follows.
//  Config: in IDLE with config_en=1, cfg<={iconfig,cfg[CONF_LEN-1:1]} (LSB sent first). Fields
//   {nPeriod,nLMAC,nSHFT} = cfg MSB..LSB. config_en outside IDLE ignored.
//  start in IDLE: any field==0 -> cfg_err<=1, stay IDLE. Else cfg_err<=0, acc<=0, cnts<=0 -> MAC.
//   Same-cycle config_en+start: start uses pre-shift cfg; shift still happens. start when busy ignored.
//  MAC: beat when in_en=1: acc_i<=acc_i+w_i*f_i, mac_cnt++. in_en=0 stalls. Beat nLMAC -> SHFT.
//  SHFT: nSHFT cycles, in_en ignored. Cycle 0: opsum_i<=acc_i+ipsum_i, out_en<=1 (visible next
//   cycle, one cycle wide). End: per_cnt++; per_cnt==nPeriod -> IDLE, else acc<=0 -> MAC.
//  Latency: out_en high 2 cycles after posedge accepting final beat; min pulse spacing nLMAC+nSHFT.
//  busy=1 from cycle after accepted start through last SHFT cycle.
//  Arithmetic: signed two's complement; product 2*WIDTH sign-extended to A_WIDTH; acc and acc+ipsum
//   per CONFIGURATION overflow rule. Lanes fully independent.
// CONFIGURATION
//  PE_SAT_EN defined: acc update and acc+ipsum saturate to signed A_WIDTH max/min on overflow.
//  PE_SAT_EN undefined: wrap modulo 2^A_WIDTH. No other behavioural difference.
// TESTING
//  1 rst=0 2 cycles mid-garbage -> opsum=0, out_en=0, busy=0, cfg_err=0.
//  2 cfg {2,8,3} LSB first, start, w=f=1, ipsum=2, 8 beats x2 -> two out_en pulses, all lanes opsum=10.
//  3 same cfg, 8 beats spread over 12 cycles (4 gaps) -> opsum=10, out_en 4 cycles later than test 2.
//  4 cfg nLMAC=0, start -> cfg_err=1, busy stays 0; valid start next -> cfg_err clears.
//  5 w=f=0x7FFF, nLMAC=5, ipsum=0, nPeriod=1 -> SAT: 0x0_FFFF_FFFF; wrap: -3221553147.
//  6 rst=0 on 4th MAC beat -> busy 0, no out_en ever; per-lane distinct operands check lane mapping.

Source files
------------

// File: rtl/pe_vec.sv
// pe_vec: LANES independent signed MAC lanes sharing one serial config port
// and one control FSM. A run is nPeriod periods; each period accumulates
// nLMAC operand beats, then spends nSHFT cycles in a shift/drain phase whose
// first cycle emits acc+ipsum for every lane with a one-cycle out_en pulse.
// Config fields {nPeriod,nLMAC,nSHFT} are loaded LSB first via iconfig.
// Optional feature macro: PE_SAT_EN -- when defined, accumulation and the
// acc+ipsum output saturate to signed A_WIDTH limits; otherwise they wrap.
module pe_vec #(
    parameter int WIDTH       = 16,
    parameter int LANES       = 4,
    parameter int MAX_nPERIOD = 8,
    parameter int MAX_nLMAC   = 12288,
    parameter int MAX_nSHFT   = 192,
    parameter int ACC_GUARD   = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      iconfig,
    input  logic                                      config_en,
    input  logic                                      in_en,
    input  logic [LANES*WIDTH-1:0]                    weight,
    input  logic [LANES*WIDTH-1:0]                    feature,
    input  logic [LANES*(2*WIDTH+ACC_GUARD)-1:0]      ipsum,
    output logic [LANES*(2*WIDTH+ACC_GUARD)-1:0]      opsum,
    output logic                                      out_en,
    output logic                                      busy,
    output logic                                      cfg_err
);

    localparam int A_WIDTH  = 2*WIDTH + ACC_GUARD;
    localparam int PW       = $clog2(MAX_nPERIOD);
    localparam int LW       = $clog2(MAX_nLMAC);
    localparam int SW       = $clog2(MAX_nSHFT);
    localparam int CONF_LEN = PW + LW + SW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SHFT = 2'd2
    } state_t;

    // Signed product of two operands, sign-extended to accumulator width.
    function automatic logic [A_WIDTH-1:0] mul_ext(input logic [WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0] f);
        logic signed [2*WIDTH-1:0] p;
        p = $signed(w) * $signed(f);
        return {{ACC_GUARD{p[2*WIDTH-1]}}, p};
    endfunction

    // Accumulator-width signed add; clamps on overflow when saturation is built in.
    function automatic logic [A_WIDTH-1:0] acc_add(input logic [A_WIDTH-1:0] a,
                                                   input logic [A_WIDTH-1:0] b);
        logic [A_WIDTH-1:0] s;
        s = a + b;
`ifdef PE_SAT_EN
        if ((a[A_WIDTH-1] == b[A_WIDTH-1]) && (s[A_WIDTH-1] != a[A_WIDTH-1])) begin
            s = a[A_WIDTH-1] ? {1'b1, {(A_WIDTH-1){1'b0}}} : {1'b0, {(A_WIDTH-1){1'b1}}};
        end else begin
            s = a + b;
        end
`endif
        return s;
    endfunction

    state_t                       state_q, state_d;
    logic [CONF_LEN-1:0]          cfg_q, cfg_d;
    logic [LW-1:0]                mac_q, mac_d;
    logic [SW-1:0]                shf_q, shf_d;
    logic [PW-1:0]                per_q, per_d;
    logic [A_WIDTH-1:0]           acc_q [LANES];
    logic [A_WIDTH-1:0]           acc_d [LANES];
    logic [LANES*A_WIDTH-1:0]     opsum_q, opsum_d;
    logic                         out_en_q, out_en_d;
    logic                         busy_q, busy_d;
    logic                         cfg_err_q, cfg_err_d;

    logic [PW-1:0]                n_per_s;
    logic [LW-1:0]                n_lmac_s;
    logic [SW-1:0]                n_shft_s;

    assign n_per_s  = cfg_q[CONF_LEN-1 -: PW];
    assign n_lmac_s = cfg_q[SW +: LW];
    assign n_shft_s = cfg_q[SW-1:0];

    assign opsum   = opsum_q;
    assign out_en  = out_en_q;
    assign busy    = busy_q;
    assign cfg_err = cfg_err_q;

    // Next-state logic: config shifting, run start/check, MAC beats, drain phase.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        mac_d     = mac_q;
        shf_d     = shf_q;
        per_d     = per_q;
        acc_d     = acc_q;
        opsum_d   = opsum_q;
        out_en_d  = 1'b0;
        cfg_err_d = cfg_err_q;
        case (state_q)
            ST_IDLE: begin
                if (config_en) begin
                    cfg_d = {iconfig, cfg_q[CONF_LEN-1:1]};
                end else begin
                    cfg_d = cfg_q;
                end
                // Start decisions use the pre-shift config contents.
                if (start) begin
                    if ((n_per_s == '0) || (n_lmac_s == '0) || (n_shft_s == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        mac_d     = '0;
                        shf_d     = '0;
                        per_d     = '0;
                        for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                        state_d   = ST_MAC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (in_en) begin
                    for (int i = 0; i < LANES; i++) begin
                        acc_d[i] = acc_add(acc_q[i],
                                           mul_ext(weight[i*WIDTH +: WIDTH], feature[i*WIDTH +: WIDTH]));
                    end
                    if (mac_q == (n_lmac_s - LW'(1))) begin
                        mac_d   = '0;
                        state_d = ST_SHFT;
                    end else begin
                        mac_d = mac_q + LW'(1);
                    end
                end else begin
                    mac_d = mac_q;
                end
            end
            ST_SHFT: begin
                if (shf_q == '0) begin
                    for (int i = 0; i < LANES; i++) begin
                        opsum_d[i*A_WIDTH +: A_WIDTH] = acc_add(acc_q[i], ipsum[i*A_WIDTH +: A_WIDTH]);
                    end
                    out_en_d = 1'b1;
                end else begin
                    out_en_d = 1'b0;
                end
                if (shf_q == (n_shft_s - SW'(1))) begin
                    shf_d = '0;
                    if ((per_q + PW'(1)) == n_per_s) begin
                        per_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        per_d   = per_q + PW'(1);
                        for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                        state_d = ST_MAC;
                    end
                end else begin
                    shf_d = shf_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            mac_q     <= '0;
            shf_q     <= '0;
            per_q     <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
            opsum_q   <= '0;
            out_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            mac_q     <= mac_d;
            shf_q     <= shf_d;
            per_q     <= per_d;
            for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
            opsum_q   <= opsum_d;
            out_en_q  <= out_en_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pe_vec.sv
// Scoreboard bench for pe_vec: the driver pushes expected opsum vectors and
// their arrival cycle; a negedge monitor pops and compares on every out_en.
module tb_pe_vec;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int A_W   = 2*WIDTH + 1;
    localparam longint MAXV = (longint'(1) <<< (A_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (A_W-1));

    logic clk = 1'b0;
    logic rst, start, iconfig, config_en, in_en;
    logic [LANES*WIDTH-1:0] weight, feature;
    logic [LANES*A_W-1:0]   ipsum, opsum;
    logic out_en, busy, cfg_err;

    typedef struct {
        logic [LANES*A_W-1:0] v;
        int                   c;
    } exp_t;
    exp_t q[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    pe_vec dut (
        .clk(clk), .rst(rst), .start(start), .iconfig(iconfig), .config_en(config_en),
        .in_en(in_en), .weight(weight), .feature(feature), .ipsum(ipsum),
        .opsum(opsum), .out_en(out_en), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Overflow rule of the accumulator, computed on plain integers.
    function automatic longint ovf(input longint x);
`ifdef PE_SAT_EN
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
`else
        longint t;
        t = x & ((longint'(1) <<< A_W) - 1);
        if (t > MAXV) t = t - (longint'(1) <<< A_W);
        return t;
`endif
    endfunction

    // Monitor: every out_en pulse must match the oldest expected vector and cycle.
    always @(negedge clk) begin
        if (out_en === 1'b1) begin
            exp_t e;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_out_en cyc=%0d opsum=%h", cyc, opsum);
            end else begin
                e = q.pop_front();
                if (opsum !== e.v || cyc != e.c) begin
                    miscompares++;
                    $display("FAIL opsum got=%h at cyc %0d, want=%h at cyc %0d", opsum, cyc, e.v, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic load_cfg(input int nper, input int nlmac, input int nshft);
        logic [24:0] v;
        v = {3'(nper), 14'(nlmac), 8'(nshft)};
        config_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            iconfig = v[i];
            tick();
        end
        config_en = 1'b0;
        iconfig   = 1'b0;
    endtask

    // mode: 0 w=f=1, 1 w=f=0x7FFF, 2 random, 3 corner mix. ipmode: 0 ipsum=2, 1 zero, 2 random.
    task automatic run(input int nper, input int nlmac, input int nshft, input int gap_pct,
                       input int gapmask, input int mode, input int ipmode);
        longint acc[LANES];
        longint ip[LANES];
        logic signed [WIDTH-1:0] w, f;
        logic [63:0] tmp;
        exp_t e;
        load_cfg(nper, nlmac, nshft);
        for (int i = 0; i < LANES; i++) begin
            ip[i] = (ipmode == 0) ? 64'sd2 : (ipmode == 1) ? 64'sd0 : longint'($signed($urandom));
            tmp = ip[i];
            ipsum[i*A_W +: A_W] = tmp[A_W-1:0];
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("cfg_err_after_start", {63'd0, cfg_err}, 64'd0);
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < LANES; i++) acc[i] = 0;
            for (int b = 0; b < nlmac; b++) begin
                if (gapmask[b % 32]) begin
                    in_en = 1'b0;
                    weight = {$urandom, $urandom};
                    tick();
                end
                while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    in_en = 1'b0;
                    feature = {$urandom, $urandom};
                    tick();
                end
                for (int i = 0; i < LANES; i++) begin
                    case (mode)
                        0: begin w = 16'sd1; f = 16'sd1; end
                        1: begin w = 16'sh7FFF; f = 16'sh7FFF; end
                        2: begin w = 16'($urandom); f = 16'($urandom); end
                        default: begin
                            w = ($urandom_range(1) == 0) ? 16'sh7FFF : 16'sh8000;
                            f = ($urandom_range(2) == 0) ? 16'($urandom) : 16'sh8000;
                        end
                    endcase
                    weight[i*WIDTH +: WIDTH]  = w;
                    feature[i*WIDTH +: WIDTH] = f;
                    acc[i] = ovf(acc[i] + longint'(w) * longint'(f));
                end
                in_en = 1'b1;
                if (b == nlmac - 1) begin
                    for (int i = 0; i < LANES; i++) begin
                        tmp = ovf(acc[i] + ip[i]);
                        e.v[i*A_W +: A_W] = tmp[A_W-1:0];
                    end
                    e.c = cyc + 2;
                    q.push_back(e);
                end
                tick();
            end
            // Drain phase: in_en must be ignored, so keep driving garbage beats.
            for (int s = 0; s < nshft; s++) begin
                in_en = 1'b1;
                weight = {$urandom, $urandom};
                feature = {$urandom, $urandom};
                tick();
            end
            in_en = 1'b0;
            chk("busy_period_end", {63'd0, busy}, (p == nper - 1) ? 64'd0 : 64'd1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; iconfig = 1'b0; config_en = 1'b0; in_en = 1'b0;
        weight = '0; feature = '0; ipsum = '0;

        // Reset with garbage on inputs.
        rst = 1'b0; start = 1'b1; in_en = 1'b1; config_en = 1'b1; iconfig = 1'b1;
        weight = {$urandom, $urandom}; ipsum = {$urandom, $urandom, $urandom, $urandom, $urandom};
        tick(); tick();
        chk("rst_opsum", {63'd0, |opsum}, 64'd0);
        chk("rst_out_en", {63'd0, out_en}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        rst = 1'b1; start = 1'b0; in_en = 1'b0; config_en = 1'b0; iconfig = 1'b0;
        tick();

        // Two periods, w=f=1, ipsum=2: each pulse carries 10 per lane.
        run(2, 8, 3, 0, 0, 0, 0);
        // Same with four idle cycles inserted among the beats.
        run(2, 8, 3, 0, 32'h000000B4, 0, 0);

        // Zero nLMAC: start rejected, flag sticky, stays idle.
        load_cfg(2, 0, 3);
        start = 1'b1; tick(); start = 1'b0;
        chk("cfg_err_set", {63'd0, cfg_err}, 64'd1);
        chk("cfg_err_busy", {63'd0, busy}, 64'd0);
        tick();
        chk("cfg_err_sticky", {63'd0, cfg_err}, 64'd1);
        // Valid start clears it (checked inside run).
        run(1, 3, 2, 0, 0, 2, 2);

        // Reset while cfg_err set and opsum nonzero.
        load_cfg(0, 4, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("cfg_err_set2", {63'd0, cfg_err}, 64'd1);
        rst = 1'b0; tick(); tick(); rst = 1'b1;
        chk("rst2_opsum", {63'd0, |opsum}, 64'd0);
        chk("rst2_cfg_err", {63'd0, cfg_err}, 64'd0);

        // Overflow corner: 5 x 0x7FFF^2 exceeds the 33-bit signed range.
        run(1, 5, 2, 0, 0, 1, 1);

        // Reset on the 4th beat: run aborts, no pulse afterwards, config cleared.
        load_cfg(1, 8, 2);
        start = 1'b1; tick(); start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            weight = {$urandom, $urandom}; feature = {$urandom, $urandom};
            in_en = 1'b1;
            if (b == 3) rst = 1'b0;
            tick();
        end
        rst = 1'b1; in_en = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_opsum", {63'd0, |opsum}, 64'd0);
        for (int k = 0; k < 20; k++) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("abort_cfg_cleared", {63'd0, cfg_err}, 64'd1);
        chk("abort_busy_idle", {63'd0, busy}, 64'd0);

        // Randomized runs with per-lane distinct operands and random gaps.
        for (int r = 0; r < 12; r++) begin
            run($urandom_range(3, 1), $urandom_range(6, 1), $urandom_range(4, 1),
                30, 0, (r % 2 == 0) ? 2 : 3, 2);
        end

        for (int k = 0; k < 5; k++) tick();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
